// File: rtl/time_config_ctrl.sv
// rtl/time_config_ctrl.sv - user-side time-setting sequencer for the RTC
//
// Purpose:
//   Debounced push-button pulses drive an IDLE -> LOAD -> EDIT -> COMMIT flow.
//   The flow edits a local hour/min/sec shadow copy of the RTC time. When the
//   edit is confirmed, a one-cycle wr_strobe asks the RTC interface to load
//   the shadow values.
//
// Optional feature:
//   The macro TIME_CONFIG_BLINK_EN enables a BLINK_DIV-based blink generator
//   for the selected field. When the macro is not defined, blink follows
//   cfg_active.
//
// Ports:
//   clk         system clock, rising-edge active
//   listo_rst   asynchronous active-high reset
//   push_cfg    pulse: enter config / confirm
//   push_up     pulse: increment selected field
//   push_down   pulse: decrement selected field
//   push_left   pulse: select previous field
//   push_right  pulse: select next field
//   hour_in     current RTC hours   (0-23)
//   min_in      current RTC minutes (0-59)
//   sec_in      current RTC seconds (0-59)
//   hour_out    shadow hours
//   min_out     shadow minutes
//   sec_out     shadow seconds
//   field_sel   selected field: 0 hour, 1 min, 2 sec
//   cfg_active  high while in LOAD or EDIT
//   wr_strobe   one-cycle pulse in COMMIT
//   blink       display blink enable for the selected field

module time_config_ctrl #(
    parameter int unsigned TIMEOUT   = 500000000,
    parameter int          TO_W      = 32,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       listo_rst,
    input  logic       push_cfg,
    input  logic       push_up,
    input  logic       push_down,
    input  logic       push_left,
    input  logic       push_right,
    input  logic [4:0] hour_in,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    output logic [4:0] hour_out,
    output logic [5:0] min_out,
    output logic [5:0] sec_out,
    output logic [1:0] field_sel,
    output logic       cfg_active,
    output logic       wr_strobe,
    output logic       blink
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EDIT   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;

    // One-hot view of the push that wins arbitration in EDIT.
    // The priority order is cfg > right > left > up > down.
    logic act_cfg, act_right, act_left, act_up, act_down;

    always_comb begin
        act_cfg   = 1'b0;
        act_right = 1'b0;
        act_left  = 1'b0;
        act_up    = 1'b0;
        act_down  = 1'b0;
        if (state == EDIT) begin
            if (push_cfg)        act_cfg   = 1'b1;
            else if (push_right) act_right = 1'b1;
            else if (push_left)  act_left  = 1'b1;
            else if (push_up)    act_up    = 1'b1;
            else if (push_down)  act_down  = 1'b1;
        end
    end

    // Modulo helpers. The shadow registers only hold in-range values,
    // so an equality test against the top value is enough to detect wrap.
    function automatic logic [4:0] hour_inc(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [4:0] hour_dec(input logic [4:0] h);
        return (h == 5'd0) ? 5'd23 : h - 5'd1;
    endfunction

    function automatic logic [5:0] sexa_inc(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] sexa_dec(input logic [5:0] v);
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    always_ff @(posedge clk or posedge listo_rst) begin
        if (listo_rst) begin
            state      <= IDLE;
            to_cnt     <= '0;
            hour_out   <= '0;
            min_out    <= '0;
            sec_out    <= '0;
            field_sel  <= 2'd0;
            cfg_active <= 1'b0;
            wr_strobe  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_strobe <= 1'b0;
                    to_cnt    <= '0;
                    if (push_cfg) begin
                        state      <= LOAD;
                        cfg_active <= 1'b1;
                    end
                end

                LOAD: begin
                    // Snapshot the live RTC time. Any pushes in this cycle
                    // are ignored.
                    hour_out  <= hour_in;
                    min_out   <= min_in;
                    sec_out   <= sec_in;
                    field_sel <= 2'd0;
                    to_cnt    <= '0;
                    state     <= EDIT;
                end

                EDIT: begin
                    if (act_cfg) begin
                        state      <= COMMIT;
                        cfg_active <= 1'b0;
                        wr_strobe  <= 1'b1;
                        to_cnt     <= '0;
                    end else if (act_right) begin
                        field_sel <= (field_sel == 2'd2) ? 2'd0 : field_sel + 2'd1;
                        to_cnt    <= '0;
                    end else if (act_left) begin
                        field_sel <= (field_sel == 2'd0) ? 2'd2 : field_sel - 2'd1;
                        to_cnt    <= '0;
                    end else if (act_up) begin
                        case (field_sel)
                            2'd0:    hour_out <= hour_inc(hour_out);
                            2'd1:    min_out  <= sexa_inc(min_out);
                            2'd2:    sec_out  <= sexa_inc(sec_out);
                            default: ;
                        endcase
                        to_cnt <= '0;
                    end else if (act_down) begin
                        case (field_sel)
                            2'd0:    hour_out <= hour_dec(hour_out);
                            2'd1:    min_out  <= sexa_dec(min_out);
                            2'd2:    sec_out  <= sexa_dec(sec_out);
                            default: ;
                        endcase
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        // On inactivity, abort without writing. The shadow
                        // values stay visible, but they are not committed.
                        state      <= IDLE;
                        cfg_active <= 1'b0;
                        to_cnt     <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                COMMIT: begin
                    wr_strobe <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    cfg_active <= 1'b0;
                    wr_strobe  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TIME_CONFIG_BLINK_EN
    localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

    logic [BL_W-1:0] bl_cnt;
    logic            blink_q;

    // Blink starts visible when EDIT is entered. An up or down edit makes
    // the field visible again and restarts the phase, so the new value is
    // never hidden right after it changes.
    always_ff @(posedge clk or posedge listo_rst) begin
        if (listo_rst) begin
            bl_cnt  <= '0;
            blink_q <= 1'b0;
        end else if (state == LOAD) begin
            bl_cnt  <= '0;
            blink_q <= 1'b1;
        end else if (state == EDIT && !act_cfg && !(to_cnt == TO_LAST && !(act_right || act_left || act_up || act_down))) begin
            if (act_up || act_down) begin
                bl_cnt  <= '0;
                blink_q <= 1'b1;
            end else if (bl_cnt == BL_LAST) begin
                bl_cnt  <= '0;
                blink_q <= ~blink_q;
            end else begin
                bl_cnt <= bl_cnt + 1'b1;
            end
        end else begin
            bl_cnt  <= '0;
            blink_q <= 1'b0;
        end
    end

    assign blink = blink_q;
`else
    assign blink = cfg_active;
`endif

endmodule

// File: tb/tb_time_config_ctrl.sv
// tb/tb_time_config_ctrl.sv - directed self-checking bench for time_config_ctrl
module tb_time_config_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push_cfg = 0, push_up = 0, push_down = 0, push_left = 0, push_right = 0;
    logic [4:0] hour_in = '0;
    logic [5:0] min_in = '0;
    logic [5:0] sec_in = '0;
    logic [4:0] hour_out;
    logic [5:0] min_out;
    logic [5:0] sec_out;
    logic [1:0] field_sel;
    logic       cfg_active;
    logic       wr_strobe;
    logic       blink;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    time_config_ctrl #(.TIMEOUT(20), .TO_W(8), .BLINK_DIV(4)) dut (
        .clk(clk), .listo_rst(rst),
        .push_cfg(push_cfg), .push_up(push_up), .push_down(push_down),
        .push_left(push_left), .push_right(push_right),
        .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
        .hour_out(hour_out), .min_out(min_out), .sec_out(sec_out),
        .field_sel(field_sel), .cfg_active(cfg_active),
        .wr_strobe(wr_strobe), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_strobe === 1'b1) strobes++;

    // Bits are {cfg, right, left, up, down}. Call this at a negedge; it
    // returns at the next negedge, after the DUT has sampled the pulse.
    task automatic push(input logic [4:0] p);
        {push_cfg, push_right, push_left, push_up, push_down} = p;
        @(negedge clk);
        {push_cfg, push_right, push_left, push_up, push_down} = 5'b0;
    endtask

    task automatic enter(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        hour_in = h; min_in = m; sec_in = s;
        push(5'b10000);
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [30:0] got;
        int s0;
        checks++;
        got = {hour_out, min_out, sec_out, field_sel, cfg_active, wr_strobe, blink};
        if (got !== 31'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", got); end
        @(negedge clk); rst = 1'b0;
        enter(5'd7, 6'd8, 6'd9);
        push(5'b00010);
        checks++;
        if (hour_out !== 5'd8) begin errors++; $display("FAIL pre_reset_hour got %0d exp 8", hour_out); end
        s0 = strobes;
        rst = 1'b1;
        #1;
        checks++;
        got = {hour_out, min_out, sec_out, field_sel, cfg_active, wr_strobe, blink};
        if (got !== 31'd0) begin errors++; $display("FAIL midedit_reset got %h exp 0", got); end
        #49;
        rst = 1'b0;
        push(5'b00010);
        @(negedge clk);
        checks++;
        got = {hour_out, min_out, sec_out, field_sel, cfg_active, wr_strobe, blink};
        if (got !== 31'd0) begin errors++; $display("FAIL idle_push_up got %h exp 0", got); end
        checks++;
        if (strobes !== s0) begin errors++; $display("FAIL reset_no_strobe got %0d exp %0d", strobes - s0, 0); end
    endtask

    task automatic test_load_edit;
        hour_in = 5'd23; min_in = 6'd59; sec_in = 6'd0;
        push(5'b10000);
        checks++;
        if (cfg_active !== 1'b1) begin errors++; $display("FAIL load_active got %b exp 1", cfg_active); end
        @(negedge clk);
        checks++;
        if ({hour_out, min_out, sec_out, field_sel} !== {5'd23, 6'd59, 6'd0, 2'd0}) begin
            errors++; $display("FAIL load_capture got %0d/%0d/%0d f%0d exp 23/59/0 f0", hour_out, min_out, sec_out, field_sel);
        end
`ifndef TIME_CONFIG_BLINK_EN
        checks++;
        if (blink !== 1'b1) begin errors++; $display("FAIL blink_follows_active got %b exp 1", blink); end
`endif
        push(5'b00010);
        checks++;
        if (hour_out !== 5'd0) begin errors++; $display("FAIL hour_wrap_up got %0d exp 0", hour_out); end
        push(5'b01000);
        push(5'b00010);
        checks++;
        if (min_out !== 6'd0 || field_sel !== 2'd1) begin
            errors++; $display("FAIL min_wrap_up got %0d f%0d exp 0 f1", min_out, field_sel);
        end
        push(5'b01000);
        push(5'b00001);
        checks++;
        if (sec_out !== 6'd59 || field_sel !== 2'd2) begin
            errors++; $display("FAIL sec_wrap_down got %0d f%0d exp 59 f2", sec_out, field_sel);
        end
        push(5'b01000);
        push(5'b00001);
        checks++;
        if (hour_out !== 5'd23) begin errors++; $display("FAIL hour_wrap_down got %0d exp 23", hour_out); end
        push(5'b00010);
    endtask

    task automatic test_field_wrap;
        checks++;
        if (field_sel !== 2'd0) begin errors++; $display("FAIL field_start got %0d exp 0", field_sel); end
        push(5'b00100);
        checks++;
        if (field_sel !== 2'd2) begin errors++; $display("FAIL field_left_wrap got %0d exp 2", field_sel); end
        push(5'b00100);
        checks++;
        if (field_sel !== 2'd1) begin errors++; $display("FAIL field_left got %0d exp 1", field_sel); end
        push(5'b01000);
        push(5'b01000);
        checks++;
        if (field_sel !== 2'd0) begin errors++; $display("FAIL field_right_wrap got %0d exp 0", field_sel); end
    endtask

    task automatic test_commit;
        int s0;
        s0 = strobes;
        push(5'b10000);
        checks++;
        if (wr_strobe !== 1'b1 || {hour_out, min_out, sec_out} !== {5'd0, 6'd0, 6'd59}) begin
            errors++; $display("FAIL commit_strobe got %b %0d/%0d/%0d exp 1 0/0/59", wr_strobe, hour_out, min_out, sec_out);
        end
        @(negedge clk);
        checks++;
        if (wr_strobe !== 1'b0 || cfg_active !== 1'b0) begin
            errors++; $display("FAIL commit_end got ws%b ca%b exp ws0 ca0", wr_strobe, cfg_active);
        end
        checks++;
        if (strobes - s0 !== 1) begin errors++; $display("FAIL commit_count got %0d exp 1", strobes - s0); end
    endtask

    task automatic test_simultaneous;
        enter(5'd5, 6'd10, 6'd20);
        push(5'b01010);
        checks++;
        if (field_sel !== 2'd1 || hour_out !== 5'd5 || min_out !== 6'd10) begin
            errors++; $display("FAIL sim_up_right got f%0d %0d/%0d exp f1 5/10", field_sel, hour_out, min_out);
        end
        push(5'b10010);
        checks++;
        if (wr_strobe !== 1'b1 || min_out !== 6'd10) begin
            errors++; $display("FAIL sim_cfg_up got ws%b min%0d exp ws1 min10", wr_strobe, min_out);
        end
        push(5'b10000);
        @(negedge clk);
        checks++;
        if (cfg_active !== 1'b0) begin errors++; $display("FAIL commit_cfg_dropped got %b exp 0", cfg_active); end
    endtask

    task automatic test_timeout;
        int s0;
        s0 = strobes;
        enter(5'd1, 6'd2, 6'd3);
        repeat (19) @(negedge clk);
        checks++;
        if (cfg_active !== 1'b1) begin errors++; $display("FAIL timeout_early got %b exp 1", cfg_active); end
        @(negedge clk);
        checks++;
        if (cfg_active !== 1'b0 || hour_out !== 5'd1 || sec_out !== 6'd3) begin
            errors++; $display("FAIL timeout_abort got ca%b %0d/%0d exp ca0 1/3", cfg_active, hour_out, sec_out);
        end
        enter(5'd1, 6'd2, 6'd3);
        repeat (14) @(negedge clk);
        push(5'b00010);
        repeat (19) @(negedge clk);
        checks++;
        if (cfg_active !== 1'b1 || hour_out !== 5'd2) begin
            errors++; $display("FAIL timeout_restart got ca%b h%0d exp ca1 h2", cfg_active, hour_out);
        end
        @(negedge clk);
        checks++;
        if (cfg_active !== 1'b0) begin errors++; $display("FAIL timeout_after_restart got %b exp 0", cfg_active); end
        checks++;
        if (strobes !== s0) begin errors++; $display("FAIL timeout_no_strobe got %0d exp 0", strobes - s0); end
    endtask

    initial begin
        #1;
        test_reset;
        test_load_edit;
        test_field_wrap;
        test_commit;
        test_simultaneous;
        test_timeout;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
